// File: rtl/led_seq_pkg.sv
// Shared encodings and sizing helper for the LED scan sequencer and its prescaler.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_UP       = 2'd0,
    ST_HOLD_TOP = 2'd1,
    ST_DOWN     = 2'd2,
    ST_HOLD_BOT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  // Ceiling log2, never below 1 so the result can always size a vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running step prescaler: one step every PRESCALE cycles while run is high.
module step_prescaler
  import led_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = 25000000
) (
  input  logic clk,
  input  logic btn,
  input  logic run,
  output logic step_c,
  output logic step_tick
);

  localparam int unsigned CW = clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_count;
  logic          r_tick;

  // Step fires on the edge where the count sits at its last value.
  assign step_c    = run && (r_count == CNT_LAST);
  assign step_tick = r_tick;

  always_ff @(posedge clk) begin
    if (btn) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= step_c;
      if (run) r_count <= step_c ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/led_scan_sequencer.sv
// Scan state machine and LED decode for the 8-LED bounce/wrap/fill display.
module led_scan_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 25000000,
  parameter int unsigned DWELL    = 2
) (
  input  logic                     clk,
  input  logic                     btn,
  input  logic                     run,
  input  logic [1:0]               mode,
  output logic                     step_tick,
  output logic [WIDTH-1:0]         Led,
  output logic [clog2(WIDTH)-1:0]  pos,
  output logic                     dir
);

  localparam int unsigned PW = clog2(WIDTH);
  localparam int unsigned DW = clog2(DWELL + 1);
  localparam logic [PW-1:0] POS_TOP  = PW'(WIDTH - 1);
  localparam logic [DW-1:0] DWELL_END = DW'(DWELL);

  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_pos, w_pos_nxt;
  logic            r_dir, w_dir_nxt;
  logic [DW-1:0]   r_dwell, w_dwell_nxt;
  logic [WIDTH-1:0] r_led, w_led_nxt;
  logic            w_step_c;
  mode_e           w_mode;

  assign w_mode = mode_e'(mode);
  assign Led    = r_led;
  assign pos    = r_pos;
  assign dir    = r_dir;

  step_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk      (clk),
    .btn      (btn),
    .run      (run),
    .step_c   (w_step_c),
    .step_tick(step_tick)
  );

  always_ff @(posedge clk) begin
    if (btn) begin
      r_state <= ST_UP;
      r_pos   <= '0;
      r_dir   <= 1'b0;
      r_dwell <= '0;
      r_led   <= WIDTH'(1);
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_dir   <= w_dir_nxt;
      r_dwell <= w_dwell_nxt;
      r_led   <= w_led_nxt;
    end
  end

  // Scan advance happens only on a step; LED decode follows next-state pos every cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_dwell_nxt = r_dwell;
    w_led_nxt   = '0;

    if (w_step_c) begin
      case (w_mode)
        MODE_WRAP: begin
          w_pos_nxt   = (r_pos == POS_TOP) ? '0 : r_pos + PW'(1);
          w_dir_nxt   = 1'b0;
          w_state_nxt = ST_UP;
          w_dwell_nxt = '0;
        end
        MODE_OFF: ;
        default: begin
          case (r_state)
            ST_UP: begin
              if (r_pos != POS_TOP) begin
                w_pos_nxt = r_pos + PW'(1);
              end else if (DWELL == 0) begin
                w_state_nxt = ST_DOWN;
                w_pos_nxt   = r_pos - PW'(1);
                w_dir_nxt   = 1'b1;
              end else begin
                w_state_nxt = ST_HOLD_TOP;
                w_dwell_nxt = DW'(1);
              end
            end
            ST_HOLD_TOP: begin
              if (r_dwell == DWELL_END) begin
                w_state_nxt = ST_DOWN;
                w_pos_nxt   = r_pos - PW'(1);
                w_dir_nxt   = 1'b1;
                w_dwell_nxt = '0;
              end else begin
                w_dwell_nxt = r_dwell + DW'(1);
              end
            end
            ST_DOWN: begin
              if (r_pos != '0) begin
                w_pos_nxt = r_pos - PW'(1);
              end else if (DWELL == 0) begin
                w_state_nxt = ST_UP;
                w_pos_nxt   = r_pos + PW'(1);
                w_dir_nxt   = 1'b0;
              end else begin
                w_state_nxt = ST_HOLD_BOT;
                w_dwell_nxt = DW'(1);
              end
            end
            default: begin
              if (r_dwell == DWELL_END) begin
                w_state_nxt = ST_UP;
                w_pos_nxt   = r_pos + PW'(1);
                w_dir_nxt   = 1'b0;
                w_dwell_nxt = '0;
              end else begin
                w_dwell_nxt = r_dwell + DW'(1);
              end
            end
          endcase
        end
      endcase
    end

    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (w_mode)
        MODE_FILL: w_led_nxt[i] = (PW'(i) <= w_pos_nxt);
        MODE_OFF:  w_led_nxt[i] = 1'b0;
        default:   w_led_nxt[i] = (PW'(i) == w_pos_nxt);
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Scoreboard bench for led_scan_sequencer with WIDTH=8, PRESCALE=4, DWELL=2.
module tb_led_scan_sequencer;

  logic       clk = 1'b0;
  logic       btn;
  logic       run;
  logic [1:0] mode;
  logic       step_tick;
  logic [7:0] Led;
  logic [2:0] pos;
  logic       dir;

  typedef struct packed {
    logic [7:0] led;
    logic [2:0] pos;
    logic       dir;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  led_scan_sequencer #(.WIDTH(8), .PRESCALE(4), .DWELL(2)) dut (
    .clk      (clk),
    .btn      (btn),
    .run      (run),
    .mode     (mode),
    .step_tick(step_tick),
    .Led      (Led),
    .pos      (pos),
    .dir      (dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (step_tick !== 1'b1 && cyc < 20);
    if (step_tick !== 1'b1) check("step_timeout", 32'(step_tick), 32'd1);
  endtask

  task automatic do_reset();
    btn = 1'b1;
    run = 1'b1;
    tick();
    tick();
    btn = 1'b0;
  endtask

  // Bounce position after k steps from reset: up 7, hold 2, down 7, hold 2.
  function automatic exp_t bounce_exp(input int k);
    int   m;
    exp_t e;
    m = k % 18;
    if (m == 0) m = 18;
    if (m <= 7)       begin e.pos = 3'(m);      e.dir = 1'b0; end
    else if (m <= 9)  begin e.pos = 3'd7;       e.dir = 1'b0; end
    else if (m <= 16) begin e.pos = 3'(16 - m); e.dir = 1'b1; end
    else              begin e.pos = 3'd0;       e.dir = 1'b1; end
    e.led = 8'd1 << e.pos;
    return e;
  endfunction

  task automatic push_bounce(input int k_first, input int k_last);
    for (int k = k_first; k <= k_last; k++) sb.push_back(bounce_exp(k));
  endtask

  task automatic drain(input int n, input string tag, output int total_cyc);
    int   cyc;
    exp_t e;
    total_cyc = 0;
    for (int i = 0; i < n; i++) begin
      wait_step(cyc);
      total_cyc += cyc;
      if (sb.size() == 0) begin
        check({tag, "_sb_underflow"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_led"}, 32'(Led), 32'(e.led));
        check({tag, "_pos"}, 32'(pos), 32'(e.pos));
        check({tag, "_dir"}, 32'(dir), 32'(e.dir));
      end
    end
  endtask

  initial begin
    int   cyc;
    int   total;
    exp_t e;

    btn  = 1'b1;
    run  = 1'b1;
    mode = 2'b00;

    // Reset held with run active
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_led", 32'(Led), 32'h01);
      check("rst_pos", 32'(pos), 32'd0);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_tick", 32'(step_tick), 32'd0);
    end
    btn = 1'b0;
    wait_step(cyc);
    check("first_step_latency", 32'(cyc), 32'd4);
    check("first_step_led", 32'(Led), 32'h02);

    // Full bounce period plus one step
    do_reset();
    mode = 2'b00;
    push_bounce(1, 19);
    drain(18, "bounce", total);
    check("bounce_period_cycles", 32'(total), 32'd72);
    drain(1, "bounce_wrap", total);

    // Wrap from reset
    do_reset();
    mode = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      e.pos = 3'(k % 8);
      e.dir = 1'b0;
      e.led = 8'd1 << e.pos;
      sb.push_back(e);
    end
    drain(9, "wrap", total);

    // Switch to wrap while heading down at pos 5
    do_reset();
    mode = 2'b00;
    push_bounce(1, 11);
    drain(11, "pre_wrap", total);
    mode = 2'b01;
    e.pos = 3'd6;
    e.dir = 1'b0;
    e.led = 8'h40;
    sb.push_back(e);
    drain(1, "wrap_from_down", total);

    // Fill and off decode
    do_reset();
    mode = 2'b00;
    push_bounce(1, 3);
    drain(3, "pre_fill", total);
    mode = 2'b10;
    tick();
    check("fill_led", 32'(Led), 32'h0F);
    mode = 2'b11;
    tick();
    check("off_led", 32'(Led), 32'h00);
    for (int i = 0; i < 3; i++) begin
      wait_step(cyc);
      check("off_pos_frozen", 32'(pos), 32'd3);
      check("off_led_dark", 32'(Led), 32'h00);
    end
    mode = 2'b10;
    tick();
    check("fill_again_led", 32'(Led), 32'h0F);

    // Freeze with run low at prescaler count 2
    do_reset();
    mode = 2'b00;
    push_bounce(1, 2);
    drain(2, "pre_freeze", total);
    tick();
    tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("freeze_tick", 32'(step_tick), 32'd0);
      check("freeze_pos", 32'(pos), 32'd2);
      check("freeze_led", 32'(Led), 32'h04);
    end
    run = 1'b1;
    wait_step(cyc);
    check("resume_latency", 32'(cyc), 32'd2);
    check("resume_pos", 32'(pos), 32'd3);
    check("resume_led", 32'(Led), 32'h08);

    // Reset pulse during top hold
    do_reset();
    mode = 2'b00;
    push_bounce(1, 8);
    drain(8, "pre_hold", total);
    tick();
    btn = 1'b1;
    tick();
    btn = 1'b0;
    check("hold_rst_led", 32'(Led), 32'h01);
    check("hold_rst_pos", 32'(pos), 32'd0);
    check("hold_rst_dir", 32'(dir), 32'd0);
    check("hold_rst_tick", 32'(step_tick), 32'd0);
    push_bounce(1, 4);
    wait_step(cyc);
    check("hold_rst_latency", 32'(cyc), 32'd4);
    e = sb.pop_front();
    check("hold_rst_step_led", 32'(Led), 32'(e.led));
    drain(3, "post_hold_rst", total);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scan_sequencer.md
Name: led_scan_sequencer

Overview:
Controller that sequences the 8-LED display datapath. It owns a parameterised step prescaler and a scan state machine that decides which LEDs light on every step. It supports bounce (Knight Rider), wrap, fill and off patterns, with a configurable dwell at the ends. It sits between the board clock/button and the Led pins, replacing ad-hoc counter-driven LED logic in the top level.

Parameters:
WIDTH, 8, number of LEDs driven; minimum 2.
PRESCALE, 25000000, clk cycles per scan step; minimum 1.
DWELL, 2, extra steps held at each end in bounce/fill modes; 0 means no hold.

Ports:
clk  in  1  system clock; all logic on rising edge.
btn  in  1  reset, synchronous, active-high.
run  in  1  1 = prescaler and scan advance; 0 = freeze everything except mode decode.
mode  in  2  00 bounce, 01 wrap, 10 fill, 11 off.
step_tick  out  1  one-cycle pulse, coincident with each scan step.
Led  out  WIDTH  registered LED drive.
pos  out  clog2(WIDTH)  current scan position.
dir  out  1  0 = toward MSB, 1 = toward LSB.

Behaviour:
- Reset (btn=1 at clk edge, overrides run): prescaler=0, state=UP, pos=0, dir=0, dwell_cnt=0, step_tick=0, Led=1 (bit0 set). Reset mid-operation or mid-hold has the same effect on the next edge.
- Prescaler: counts 0..PRESCALE-1 while run=1 and wraps to 0 after PRESCALE-1. A step occurs on the edge where count==PRESCALE-1. step_tick is registered and is high for exactly the cycle after that edge, aligned with the updated pos. PRESCALE=1 gives a step every cycle. run=0 holds the count, does not clear it, and forces step_tick=0.
- States: UP, HOLD_TOP, DOWN, HOLD_BOT. Transitions occur only on a step.
- UP, pos<WIDTH-1: pos+1.
- UP, pos==WIDTH-1: if DWELL==0, go to DOWN with pos-1 and dir=1. Otherwise go to HOLD_TOP with dwell_cnt=1.
- HOLD_TOP: if dwell_cnt==DWELL, go to DOWN with pos-1, dir=1, dwell_cnt=0. Otherwise dwell_cnt+1.
- DOWN and HOLD_BOT: mirror of UP and HOLD_TOP at pos==0. Leaving HOLD_BOT sets dir=0 and pos+1.
- Wrap mode (01): on a step, pos=(pos+1) mod WIDTH, dir=0, state=UP, dwell_cnt=0. If entered while dir=1, dir is forced to 0 at the next step.
- Off mode (11): pos, dir, state and dwell are frozen; the prescaler keeps running and step_tick keeps pulsing.
- Mode changes take effect at the next step for pos/state, and on the next clock edge for Led decode.
- Returning to bounce from wrap at pos==WIDTH-1: the next step enters HOLD_TOP (or DOWN if DWELL==0).
- Led decode (registered, updated every cycle from the next-state pos/mode):
  - bounce/wrap: one-hot bit pos.
  - fill: bits 0..pos set.
  - off: all zero.
- pos never leaves 0..WIDTH-1. There is no arithmetic overflow; dwell_cnt width is clog2(DWELL+1), minimum 1.
- Bounce period = 2*(WIDTH-1) + 2*DWELL steps.

Decomposition:
- Shared header/package led_seq_pkg: state encodings (UP=0, HOLD_TOP=1, DOWN=2, HOLD_BOT=3), mode encodings, clog2 function.
- Sub-module step_prescaler (clk, btn, run, PRESCALE → step pulse). It is the parameterised counter, reusable by other display blocks.
- FSM and Led decode stay in led_scan_sequencer.

Test Plan:
All scenarios use WIDTH=8, PRESCALE=4, DWELL=2.
1. btn=1 for 5 cycles with run=1 -> Led=8'h01, pos=0, dir=0, step_tick=0 throughout. After btn falls, first step_tick 4 cycles later with Led=8'h02.
2. Bounce, 18 steps -> Led walks 01,02,...,80; holds 80 for 2 steps; then 40,...,01; holds 01 for 2 steps. Period 72 cycles. dir toggles 0→1 leaving HOLD_TOP and 1→0 leaving HOLD_BOT.
3. Wrap mode from reset, 9 steps -> 02,04,...,80,01,02. dir stays 0. Switch to wrap at pos=5 with dir=1 -> next step pos=6, dir=0.
4. Fill mode at pos=3 -> Led=8'h0F the next cycle. Switch to mode 11 -> Led=8'h00 next cycle, pos stays 3 across 3 step_ticks. Back to 10 -> Led=8'h0F.
5. run=0 for 10 cycles starting at prescaler count 2 -> no step_tick, outputs frozen. After run=1, the next step_tick arrives 2 cycles later.
6. btn pulsed for 1 cycle during HOLD_TOP (dwell_cnt=1) -> next edge Led=8'h01, pos=0, dir=0, prescaler=0. Normal bounce resumes with the first step 4 cycles after btn falls.
